pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 135 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter, next-PC selection and an optional return-address stack for JAL/JS.
// Optional feature macro: PC_FETCH_RETURN_STACK_EN (defined = hardware return stack; undefined = JS uses rs_data).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [1:0]  Jump,
  input  logic        Link,
  input  logic        Branch,
  input  logic        BranchTaken,
  input  logic        halt,
  input  logic [25:0] jump_target,
  input  logic [31:0] branch_offset,
  input  logic [31:0] rs_data,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_plus1,
  output logic        halted,
  output logic [3:0]  ras_depth,
  output logic        ras_overflow,
  output logic        ras_underflow
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned DEPTH_W = 4;
  localparam logic [1:0]  JUMP_J  = 2'b01;
  localparam logic [1:0]  JUMP_JS = 2'b10;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               halted_q, halted_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               unused_c;

`ifdef PC_FETCH_RETURN_STACK_EN
  localparam int unsigned IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [PC_W-1:0] ras_top_c;
  logic            push_en_c;

  // Top entry sits one below the depth pointer; read only when depth is non-zero.
  assign ras_top_c = ras_mem[IDX_W'(depth_q - DEPTH_W'(1))];

  // Stack storage is deliberately not reset.
  always_ff @(posedge Clock) begin
    if (Reset && push_en_c) begin
      ras_mem[IDX_W'(depth_q)] <= pc_plus1;
    end
  end

  assign unused_c = ^{rs_data, imem_data[25:6]};
`else
  assign unused_c = ^{Link, imem_data[25:6], DEPTH_W'(RAS_DEPTH)};
`endif

  assign pc_plus1  = pc_q + PC_W'(1);
  assign imem_addr = pc_q;
  assign opcode    = halted_q ? 6'd0 : imem_data[31:26];
  assign funct     = halted_q ? 6'd0 : imem_data[5:0];

  assign halted        = halted_q;
  assign ras_depth     = depth_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

  // Next-PC and stack update: halt > stall > JS > J/JAL > taken branch > sequential.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
`ifdef PC_FETCH_RETURN_STACK_EN
    push_en_c = 1'b0;
`endif
    if (halted_q || halt) begin
      halted_d = 1'b1;
    end else if (!Stall) begin
      if (Jump == JUMP_JS) begin
`ifdef PC_FETCH_RETURN_STACK_EN
        if (depth_q == DEPTH_W'(0)) begin
          pc_d  = pc_plus1;
          unf_d = 1'b1;
        end else begin
          pc_d    = ras_top_c;
          depth_d = depth_q - DEPTH_W'(1);
        end
`else
        pc_d = rs_data;
`endif
      end else if (Jump == JUMP_J) begin
        pc_d = {pc_plus1[31:26], jump_target};
`ifdef PC_FETCH_RETURN_STACK_EN
        if (Link) begin
          if (depth_q == DEPTH_W'(RAS_DEPTH)) begin
            ovf_d = 1'b1;
          end else begin
            push_en_c = 1'b1;
            depth_d   = depth_q + DEPTH_W'(1);
          end
        end
`endif
      end else if (Branch && BranchTaken) begin
        pc_d = pc_plus1 + branch_offset;
      end else begin
        pc_d = pc_plus1;
      end
    end
  end

  // State register; synchronous active-low reset wins over every other input.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed stimulus queues expected state, a monitor compares after each edge.
module tb_pc_fetch_unit;

  logic        Clock, Reset, Stall, Link, Branch, BranchTaken, halt;
  logic [1:0]  Jump;
  logic [25:0] jump_target;
  logic [31:0] branch_offset, rs_data, imem_data;
  logic [31:0] imem_addr, pc_plus1;
  logic [5:0]  opcode, funct;
  logic        halted, ras_overflow, ras_underflow;
  logic [3:0]  ras_depth;

`ifdef PC_FETCH_RETURN_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [3:0]  depth;
    logic        halted;
    logic        ovf;
    logic        unf;
    logic [5:0]  opc;
    logic [5:0]  fn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_halt, exp_ovf, exp_unf;

  pc_fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Jump(Jump), .Link(Link),
    .Branch(Branch), .BranchTaken(BranchTaken), .halt(halt),
    .jump_target(jump_target), .branch_offset(branch_offset), .rs_data(rs_data),
    .imem_data(imem_data), .imem_addr(imem_addr), .opcode(opcode), .funct(funct),
    .pc_plus1(pc_plus1), .halted(halted), .ras_depth(ras_depth),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic start_cycle();
    @(negedge Clock);
    Reset = 1'b1; Stall = 1'b0; Jump = 2'b00; Link = 1'b0; Branch = 1'b0;
    BranchTaken = 1'b0; halt = 1'b0; jump_target = '0; branch_offset = '0; rs_data = '0;
  endtask

  task automatic expect_state(input string name, input logic [31:0] pc, input logic [3:0] depth);
    exp_t e;
    e.name = name; e.pc = pc; e.depth = depth;
    e.halted = exp_halt; e.ovf = exp_ovf; e.unf = exp_unf;
    e.opc = exp_halt ? 6'd0 : imem_data[31:26];
    e.fn  = exp_halt ? 6'd0 : imem_data[5:0];
    exp_q.push_back(e);
  endtask

  // Monitor: state after each rising edge is compared with the oldest queued expectation.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if ({imem_addr, pc_plus1, ras_depth, halted, ras_overflow, ras_underflow, opcode, funct} !==
            {e.pc, e.pc + 32'd1, e.depth, e.halted, e.ovf, e.unf, e.opc, e.fn}) begin
          errors++;
          $display("FAIL %s: got pc=%h pc1=%h depth=%0d halted=%b ovf=%b unf=%b opc=%h fn=%h; exp pc=%h pc1=%h depth=%0d halted=%b ovf=%b unf=%b opc=%h fn=%h",
                   e.name, imem_addr, pc_plus1, ras_depth, halted, ras_overflow, ras_underflow, opcode, funct,
                   e.pc, e.pc + 32'd1, e.depth, e.halted, e.ovf, e.unf, e.opc, e.fn);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; Stall = 1'b0; Jump = 2'b00; Link = 1'b0; Branch = 1'b0; BranchTaken = 1'b0;
    halt = 1'b0; jump_target = '0; branch_offset = '0; rs_data = '0;
    imem_data = 32'h1400_0025;
    exp_halt = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;

    start_cycle(); Reset = 1'b0; expect_state("reset", 32'd0, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      start_cycle(); expect_state($sformatf("seq%0d", i), 32'(i), 4'd0);
    end

    // Backward branch below zero, then sequential wrap to zero.
    start_cycle(); Branch = 1'b1; BranchTaken = 1'b1; branch_offset = 32'hFFFF_FFFB;
    expect_state("branch_neg_wrap", 32'hFFFF_FFFF, 4'd0);
    start_cycle(); expect_state("pc_wrap", 32'd0, 4'd0);
    start_cycle(); Jump = 2'b11; Link = 1'b1; expect_state("jump11_none", 32'd1, 4'd0);

    start_cycle(); Jump = 2'b01; jump_target = 26'd10; expect_state("j_to_10", 32'd10, 4'd0);
    start_cycle(); Branch = 1'b1; BranchTaken = 1'b1; branch_offset = 32'hFFFF_FFFB;
    expect_state("br_taken", 32'd6, 4'd0);
    start_cycle(); Jump = 2'b01; jump_target = 26'd10; expect_state("j_to_10b", 32'd10, 4'd0);
    start_cycle(); Branch = 1'b1; BranchTaken = 1'b0; branch_offset = 32'hFFFF_FFFB;
    expect_state("br_not_taken", 32'd11, 4'd0);
    start_cycle(); BranchTaken = 1'b1; branch_offset = 32'd100;
    expect_state("bt_no_branch", 32'd12, 4'd0);

    start_cycle(); Jump = 2'b01; jump_target = 26'd20; expect_state("j_to_20", 32'd20, 4'd0);
    start_cycle(); Jump = 2'b01; Link = 1'b1; jump_target = 26'h100;
    expect_state("jal_100", 32'h100, STACK_EN ? 4'd1 : 4'd0);
    start_cycle(); Jump = 2'b10; Link = 1'b1; rs_data = 32'h40;
    expect_state("js_return", STACK_EN ? 32'd21 : 32'h40, 4'd0);

`ifdef PC_FETCH_RETURN_STACK_EN
    // Nine calls into an eight-deep stack, then nine returns.
    for (int k = 0; k < 9; k++) begin
      start_cycle(); Jump = 2'b01; Link = 1'b1; jump_target = 26'(32'h200 + 32'(k) * 32'h10);
      if (k == 8) exp_ovf = 1'b1;
      expect_state($sformatf("jal%0d", k), 32'h200 + 32'(k) * 32'h10, (k < 8) ? 4'(k + 1) : 4'd8);
    end
    for (int k = 0; k < 9; k++) begin
      start_cycle(); Jump = 2'b10; rs_data = 32'hDEAD_0000;
      if (k < 7)       expect_state($sformatf("js%0d", k), 32'h201 + 32'(6 - k) * 32'h10, 4'(7 - k));
      else if (k == 7) expect_state("js7", 32'd22, 4'd0);
      else begin
        exp_unf = 1'b1;
        expect_state("js_underflow", 32'd23, 4'd0);
      end
    end
`else
    start_cycle(); Jump = 2'b01; Link = 1'b1; jump_target = 26'h300;
    expect_state("jal_no_stack", 32'h300, 4'd0);
    start_cycle(); Jump = 2'b10; rs_data = 32'h1234;
    expect_state("js_rs_data", 32'h1234, 4'd0);
`endif

    start_cycle(); Jump = 2'b01; jump_target = 26'd7; expect_state("j_to_7", 32'd7, 4'd0);
    for (int i = 0; i < 3; i++) begin
      start_cycle(); Stall = 1'b1; Jump = 2'b01; Link = 1'b1; jump_target = 26'h55;
      expect_state($sformatf("stall%0d", i), 32'd7, 4'd0);
    end
    start_cycle(); expect_state("after_stall", 32'd8, 4'd0);
    start_cycle(); imem_data = 32'hFC00_003F; expect_state("opcode_live", 32'd9, 4'd0);
    start_cycle(); halt = 1'b1; Jump = 2'b01; jump_target = 26'h55; exp_halt = 1'b1;
    expect_state("halt", 32'd9, 4'd0);
    start_cycle(); Jump = 2'b01; Link = 1'b1; jump_target = 26'h33;
    expect_state("halted_jump", 32'd9, 4'd0);
    start_cycle(); Jump = 2'b10; rs_data = 32'h77; Branch = 1'b1; BranchTaken = 1'b1;
    expect_state("halted_js", 32'd9, 4'd0);

    start_cycle(); Reset = 1'b0; Jump = 2'b01; jump_target = 26'h44;
    exp_halt = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    expect_state("reset_mid_jump", 32'd0, 4'd0);
    start_cycle(); expect_state("post_reset", 32'd1, 4'd0);
    start_cycle(); Stall = 1'b1; halt = 1'b1; exp_halt = 1'b1;
    expect_state("halt_in_stall", 32'd1, 4'd0);
    start_cycle(); Reset = 1'b0; Stall = 1'b1; exp_halt = 1'b0;
    expect_state("reset_mid_stall", 32'd0, 4'd0);
    start_cycle(); expect_state("resume", 32'd1, 4'd0);

    @(negedge Clock);
    @(negedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending, exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
